// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - sequencer that walks an 8:1 mux select and captures one bit per enabled channel
module mux_scan_ctrl #(
    parameter int DWELL = 2,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] mask,
    input  logic       mux_out,
    output logic [2:0] sel,
    output logic [7:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]       state;
    logic [7:0]       mask_q;
    logic [CNT_W-1:0] cnt;

    logic [2:0]       first_ch;
    logic [2:0]       next_ch;
    logic             next_found;

    // Lowest enabled channel of the incoming mask, used on the accepted start.
    always_comb begin
        first_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                first_ch = 3'(i);
            end
        end
    end

    // Next enabled channel strictly above the current one; no wrap-around.
    always_comb begin
        next_ch    = 3'd0;
        next_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(sel))) begin
                next_ch    = 3'(i);
                next_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sel         <= 3'd0;
            frame       <= 8'd0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            mask_q      <= 8'd0;
            cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    sel <= 3'd0;
                    if (start) begin
                        mask_q <= mask;
                        frame  <= 8'd0;
                        busy   <= 1'b1;
                        if (mask == 8'd0) begin
                            state       <= S_DONE;
                            frame_valid <= 1'b1;
                        end else begin
                            state <= S_SCAN;
                            sel   <= first_ch;
                            cnt   <= CNT_RELOAD;
                        end
                    end
                end
                S_SCAN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        // Last dwell cycle of this channel: mux_out reflects the current sel.
                        frame[sel] <= mux_out;
                        if (next_found) begin
                            sel <= next_ch;
                            cnt <= CNT_RELOAD;
                        end else begin
                            state       <= S_DONE;
                            sel         <= 3'd0;
                            frame_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (frame_ready) begin
                        state       <= S_IDLE;
                        frame_valid <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    sel         <= 3'd0;
                    frame_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - randomized self-checking bench for mux_scan_ctrl at DWELL 1, 2 and 3
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [7:0]      mask;
    logic [2:0]      start_a;
    logic [2:0]      ready_a;
    logic [2:0][7:0] pat;
    logic [2:0]      mux_a;
    logic [2:0][2:0] sel_a;
    logic [2:0][7:0] frame_a;
    logic [2:0]      fv_a;
    logic [2:0]      busy_a;

    int n_chk  = 0;
    int n_pass = 0;

    assign mux_a[0] = pat[0][sel_a[0]];
    assign mux_a[1] = pat[1][sel_a[1]];
    assign mux_a[2] = pat[2][sel_a[2]];

    mux_scan_ctrl #(.DWELL(1), .CNT_W(8)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .mask(mask), .mux_out(mux_a[0]),
        .sel(sel_a[0]), .frame(frame_a[0]), .frame_valid(fv_a[0]),
        .frame_ready(ready_a[0]), .busy(busy_a[0])
    );
    mux_scan_ctrl #(.DWELL(2), .CNT_W(8)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .mask(mask), .mux_out(mux_a[1]),
        .sel(sel_a[1]), .frame(frame_a[1]), .frame_valid(fv_a[1]),
        .frame_ready(ready_a[1]), .busy(busy_a[1])
    );
    mux_scan_ctrl #(.DWELL(3), .CNT_W(8)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(start_a[2]), .mask(mask), .mux_out(mux_a[2]),
        .sel(sel_a[2]), .frame(frame_a[2]), .frame_valid(fv_a[2]),
        .frame_ready(ready_a[2]), .busy(busy_a[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_reset(input int i);
        chk($sformatf("rst_sel[%0d]", i),   32'(sel_a[i]),   32'd0);
        chk($sformatf("rst_frame[%0d]", i), 32'(frame_a[i]), 32'd0);
        chk($sformatf("rst_fv[%0d]", i),    32'(fv_a[i]),    32'd0);
        chk($sformatf("rst_busy[%0d]", i),  32'(busy_a[i]),  32'd0);
    endtask

    // Reference: the expected select sequence is every set mask bit in ascending
    // order, each repeated dwell times; the frame is the pattern restricted to the mask.
    task automatic run_scan(input int i, input logic [7:0] m, input logic [7:0] p,
                            input logic [7:0] m_late, input int hold, input bit start_on_hs);
        int         dw;
        int         ch[$];
        logic [7:0] exp_f;
        dw    = i + 1;
        exp_f = p & m;
        for (int c = 0; c < 8; c++) if (m[c]) ch.push_back(c);

        mask       = m;
        pat[i]     = p;
        ready_a[i] = 1'b0;
        start_a[i] = 1'b1;
        step();
        start_a[i] = 1'b0;
        mask       = m_late;

        foreach (ch[k]) begin
            for (int d = 0; d < dw; d++) begin
                chk($sformatf("sel[%0d]", i),  32'(sel_a[i]),  32'(ch[k]));
                chk($sformatf("busy[%0d]", i), 32'(busy_a[i]), 32'd1);
                chk($sformatf("fv_early[%0d]", i), 32'(fv_a[i]), 32'd0);
                step();
            end
        end
        chk($sformatf("fv_rise[%0d]", i),  32'(fv_a[i]),    32'd1);
        chk($sformatf("frame[%0d]", i),    32'(frame_a[i]), 32'(exp_f));
        chk($sformatf("sel_done[%0d]", i), 32'(sel_a[i]),   32'd0);
        chk($sformatf("busy_done[%0d]", i), 32'(busy_a[i]), 32'd1);

        for (int h = 0; h < hold; h++) begin
            start_a[i] = h[0];
            pat[i]     = ~pat[i];
            step();
            chk($sformatf("hold_fv[%0d]", i),    32'(fv_a[i]),    32'd1);
            chk($sformatf("hold_frame[%0d]", i), 32'(frame_a[i]), 32'(exp_f));
            chk($sformatf("hold_busy[%0d]", i),  32'(busy_a[i]),  32'd1);
        end
        start_a[i] = start_on_hs;
        ready_a[i] = 1'b1;
        step();
        start_a[i] = 1'b0;
        ready_a[i] = 1'b0;
        chk($sformatf("hs_fv[%0d]", i),    32'(fv_a[i]),    32'd0);
        chk($sformatf("hs_busy[%0d]", i),  32'(busy_a[i]),  32'd0);
        chk($sformatf("hs_frame[%0d]", i), 32'(frame_a[i]), 32'(exp_f));
        chk($sformatf("hs_sel[%0d]", i),   32'(sel_a[i]),   32'd0);
        step();
        chk($sformatf("post_busy[%0d]", i),  32'(busy_a[i]),  32'd0);
        chk($sformatf("post_fv[%0d]", i),    32'(fv_a[i]),    32'd0);
        chk($sformatf("post_frame[%0d]", i), 32'(frame_a[i]), 32'(exp_f));
    endtask

    initial begin
        rst_n   = 1'b0;
        mask    = 8'd0;
        start_a = 3'd0;
        ready_a = 3'd0;
        pat     = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) chk_idle_reset(i);

        run_scan(0, 8'hFF, 8'hA5, 8'hFF, 0, 1'b0);
        run_scan(2, 8'h81, 8'hFF, 8'h81, 0, 1'b0);
        run_scan(1, 8'h00, 8'h5A, 8'h00, 0, 1'b0);
        run_scan(1, 8'hFF, 8'h3C, 8'hFF, 5, 1'b1);

        mask       = 8'hFF;
        pat[1]     = 8'hFF;
        start_a[1] = 1'b1;
        step();
        start_a[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("pre_rst_sel", 32'(sel_a[1]), 32'(k / 2));
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) chk_idle_reset(i);
        step();
        chk("post_rst_busy", 32'(busy_a[1]), 32'd0);
        run_scan(1, 8'hFF, 8'hC3, 8'hFF, 0, 1'b0);

        run_scan(1, 8'h0F, 8'h96, 8'hF0, 1, 1'b0);

        for (int r = 0; r < 24; r++) begin
            run_scan($urandom_range(0, 2), 8'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(0, 3), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Upstream sequencer for the 8:1 mux select path.
- Steps sel[2:0] through the enabled channels in ascending order and holds each one for a programmable dwell time.
- Samples the mux output bit for each channel and assembles an 8-bit snapshot frame.
- Hands the frame downstream through a valid/ready handshake, turning the 8:1 mux into a time-multiplexed parallel-capture path.

Parameters:
- DWELL, 2, cycles sel is held per enabled channel before sampling; legal range 1..255.
- CNT_W, 8, width of the dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  scan request; accepted only in IDLE.
- mask  input  8  channel enable, bit i = channel i; latched on the accepted start.
- mux_out  input  1  output of the 8:1 mux driven by sel.
- sel  output  3  channel select to the mux.
- frame  output  8  captured snapshot; bit i = sample of channel i.
- frame_valid  output  1  frame is complete and stable.
- frame_ready  input  1  downstream accepts the frame.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, SCAN, DONE. All outputs are registered.
- Reset: on the edge where rst_n=0, regardless of state:
  - state=IDLE, sel=0, frame=0, frame_valid=0, busy=0, latched mask=0, cnt=0.
  - Reset mid-SCAN or mid-DONE discards the partial or pending frame; no output is produced.
- IDLE, start=1 at edge t:
  - Latch mask and clear frame to 0.
  - If mask=0: go to DONE with frame=0; frame_valid=1 from t+1.
  - Otherwise: go to SCAN with sel = lowest set bit of mask and cnt = DWELL-1.
- IDLE, start=0: stay in IDLE; sel=0.
- SCAN, each edge:
  - If cnt!=0, decrement cnt.
  - If cnt==0, write frame[sel] <= mux_out.
    - If a higher enabled channel exists, set sel to the next higher enabled channel and reload cnt = DWELL-1.
    - Otherwise go to DONE and set sel=0.
- Timing:
  - Each enabled channel holds sel for exactly DWELL cycles.
  - mux_out is sampled on the last of those cycles.
  - frame_valid rises exactly N*DWELL cycles after the start edge, where N = popcount(mask).
- Channel order and masking:
  - Masked channels are skipped entirely: never driven on sel, and their frame bits are 0.
  - Channels are scanned strictly in ascending order, once per scan; there is no wrap-around.
- DONE:
  - frame_valid=1; frame is held stable while frame_valid=1 and frame_ready=0.
  - On frame_valid & frame_ready: go to IDLE with frame_valid=0; frame keeps its last value until the next accepted start.
  - frame_ready is ignored outside DONE.
- start handling:
  - Ignored in SCAN and DONE, including the DONE->IDLE handshake cycle; it is not queued.
  - A start must be presented in IDLE to be accepted. Earliest back-to-back restart: one cycle after the handshake.
- mask changes after the accepted start have no effect on the current scan.

Test Plan:
- Full mask, DWELL=1:
  - Stimulus: mask=8'hFF, mux data pattern 8'hA5 (mux_out = pattern[sel]), start pulse, frame_ready=1.
  - Required: sel sequence 0,1,...,7, one cycle each; frame_valid 8 cycles after start; frame=8'hA5; busy falls the cycle after the handshake.
- Sparse mask, DWELL=3:
  - Stimulus: mask=8'h81, pattern 8'hFF.
  - Required: sel=0 for 3 cycles, then sel=7 for 3 cycles; frame=8'h81 at 6 cycles; sel never takes the values 1..6.
- Empty mask:
  - Stimulus: mask=8'h00, start pulse.
  - Required: frame_valid=1 on the next cycle with frame=8'h00; no SCAN cycles.
- Backpressure and ignored start:
  - Stimulus: complete a scan with pattern 8'h3C; hold frame_ready=0 for 5 cycles; pulse start and change mux data during that hold.
  - Required: frame stays 8'h3C and frame_valid stays 1 throughout; the start is ignored; the handshake returns the block to IDLE; a start pulsed on the handshake cycle is not accepted.
- Reset mid-scan:
  - Stimulus: mask=8'hFF, DWELL=2; assert rst_n=0 for one edge at cycle 5.
  - Required: the next cycle shows sel=0, frame=0, frame_valid=0, busy=0; a new start then produces a correct full frame.
- Mask change mid-scan:
  - Stimulus: start with mask=8'h0F, then set mask=8'hF0 during SCAN.
  - Required: sel visits only channels 0..3; frame[7:4]=0.
